mandebrot_plot_clk_rst_seq: RTL and testbench
=============================================

Name: mandebrot_plot_clk_rst_seq

Overview:
Parametrised PLL supervisor and reset sequencer running on the PLL reference clock.
- Drives the PLL reset and qualifies its raw lock flag (synchronise, then debounce).
- Releases NUM_DOMAINS reset outputs in a staggered order.
- Retries the PLL on lock timeout; re-sequences on loss of lock.
- Sits between the board reset and every clock domain fed by the PLL wrapper.
- All outputs are refclk-domain; each consumer domain re-synchronises its rst_out bit.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset outputs (>=1).
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (>=1).
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before the PLL is retried (>=2).
- LOCK_STABLE, 1024, consecutive qualified-lock cycles required before release (>=1).
- STAGGER, 8, cycles between successive rst_out deassertions (>=1).
- CNT_W, 8, width of the status counters.

Ports:
- refclk  in  1  reference clock, 50 MHz nominal.
- rst  in  1  reset, asynchronous, active-high.
- locked_raw  in  1  PLL lock flag, asynchronous to refclk.
- pll_rst  out  1  PLL reset, active-high.
- rst_out  out  NUM_DOMAINS  per-domain reset, active-high; bit 0 is released first.
- ready  out  1  high when all rst_out bits are deasserted.
- clr_cnt  in  1  synchronous clear of the status counters (STATUS_EN only).
- lock_lost_cnt  out  CNT_W  saturating count of lock-loss events (STATUS_EN only).
- timeout_cnt  out  CNT_W  saturating count of lock timeouts (STATUS_EN only).

Behaviour:
- Clock and reset: single clock refclk; rst is asynchronous, active-high.
- Values while rst is asserted:
  - pll_rst=1, rst_out=all ones, ready=0.
  - Status counters=0, sync flops=0, state=PLL_RESET, cycle counter=0.
- Synchroniser: 2-flop on locked_raw gives locked_s, 2-cycle latency. The FSM uses only locked_s.
- Cycle counter: one shared counter, width $clog2 of the largest cycle parameter +1. It clears on every state change.
- All outputs are registered, with no combinational path from input to output.
- PLL_RESET:
  - pll_rst=1, rst_out=all ones, ready=0.
  - After exactly PLL_RST_CYCLES cycles in this state, go to WAIT_LOCK; pll_rst=0 from that cycle.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1, go to PLL_RESET and increment timeout_cnt.
- STABLE:
  - Counts consecutive cycles with locked_s=1.
  - If locked_s=0, return to WAIT_LOCK with the timeout restarted. This is not counted as a loss.
  - After the LOCK_STABLE-th consecutive high cycle, go to RELEASE.
- RELEASE:
  - rst_out[0] clears on the first RELEASE cycle.
  - rst_out[i] clears exactly STAGGER cycles after rst_out[i-1].
  - On the cycle rst_out[NUM_DOMAINS-1] clears, ready=1 and the state becomes RUN.
  - With NUM_DOMAINS=1, go directly to RUN on the first cycle.
- RUN: hold rst_out=0, ready=1.
- Lock loss (locked_s=0 in RELEASE or RUN):
  - Next cycle: rst_out=all ones, ready=0, pll_rst=1, state PLL_RESET.
  - lock_lost_cnt increments.
- rst mid-operation: outputs return immediately (asynchronously) to their reset values.
- Status counters:
  - Both saturate at 2^CNT_W-1.
  - clr_cnt together with an increment gives the value 1.
  - clr_cnt alone gives 0.
- Reset ordering invariant: rst_out is never partially re-asserted. Assertion is all bits at once; release is strictly ascending.

Optional Feature:
- Macro: MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN.
- Defined: ports clr_cnt, lock_lost_cnt and timeout_cnt exist and behave as described above.
- Undefined: those ports and counters are absent. The sequencing behaviour is otherwise identical.

Decomposition:
- Shared package mandebrot_plot_clk_pkg holds:
  - the state enum clk_rst_state_t (PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN);
  - default timing constants;
  - a helper function computing the counter width.
- One sub-module, mandebrot_plot_sync2: a parametrised-width 2-flop synchroniser with async reset to 0. It is reused by consumer domains.

Test Plan:
Bench parameters: NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, STAGGER=3, CNT_W=2.
1. Basic bring-up.
   - Stimulus: release rst; raise locked_raw 10 cycles later and hold it.
   - Required: pll_rst high for exactly 4 cycles; rst_out 111->110->100->000 with 3-cycle spacing; ready=1 with the final step.
   - Required: the first release occurs 2+1+8 cycles after locked_raw rises.
2. Lock timeout.
   - Stimulus: locked_raw held 0 for 200 cycles.
   - Required: pll_rst pulses of 4 cycles every 36 cycles; timeout_cnt saturates at 3; rst_out stays 111.
3. Chatter.
   - Stimulus: locked_raw high 5 cycles, low 2, then high.
   - Required: STABLE aborts with no release and lock_lost_cnt=0; release follows 8 qualified cycles after the final rise.
4. Lock loss.
   - Stimulus: in RUN, drop locked_raw for 1 cycle.
   - Required: 3 cycles later rst_out=111, ready=0, pll_rst=1; lock_lost_cnt=1; full re-sequence follows.
5. Lock loss mid-release.
   - Stimulus: drop lock while rst_out=110.
   - Required: rst_out returns to 111 with no further ascending step.
6. Async reset and counter clear.
   - Stimulus: assert rst asynchronously in RUN, between clock edges.
   - Required: outputs take their reset values immediately.
   - Stimulus: clr_cnt coincident with a timeout.
   - Required: timeout_cnt=1.

Source files
------------

// File: rtl/mandebrot_plot_clk_pkg.sv
// rtl/mandebrot_plot_clk_pkg.sv - shared state type, default timing and counter sizing for the clock/reset sequencer
package mandebrot_plot_clk_pkg;

   typedef enum logic [2:0] {
      PLL_RESET,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } clk_rst_state_t;

   localparam int DEF_NUM_DOMAINS    = 4;
   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 65536;
   localparam int DEF_LOCK_STABLE    = 1024;
   localparam int DEF_STAGGER        = 8;
   localparam int DEF_CNT_W          = 8;

   // One spare bit above the largest count keeps terminal compares free of wrap.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/mandebrot_plot_sync2.sv
// rtl/mandebrot_plot_sync2.sv - parametrised-width two-flop synchroniser, async reset to 0
module mandebrot_plot_sync2
   import mandebrot_plot_clk_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mandebrot_plot_clk_rst_seq.sv
// rtl/mandebrot_plot_clk_rst_seq.sv - PLL supervisor and staggered reset sequencer on refclk
// Status counters and their ports exist only with MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN defined.
module mandebrot_plot_clk_rst_seq
   import mandebrot_plot_clk_pkg::*;
#(
   parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
   parameter int STAGGER        = DEF_STAGGER,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   locked_raw,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] rst_out,
   output logic                   ready
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
   ,
   input  logic                   clr_cnt,
   output logic [CNT_W-1:0]       lock_lost_cnt,
   output logic [CNT_W-1:0]       timeout_cnt
`endif
);

   localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, STAGGER);

   localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER - 1);

   localparam logic [NUM_DOMAINS-1:0] ALL_ONES = '1;
   localparam logic [NUM_DOMAINS-1:0] LAST_BIT = NUM_DOMAINS'(1) << (NUM_DOMAINS - 1);

   logic           locked_s;
   clk_rst_state_t state;
   logic [CW-1:0]  cnt;
   logic           ev_loss;
   logic           ev_timeout;

   mandebrot_plot_sync2 #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (locked_raw),
      .q   (locked_s)
   );

   always_comb begin
      ev_loss    = !locked_s && (state == RELEASE || state == RUN);
      ev_timeout = !locked_s && (state == WAIT_LOCK) && (cnt == TIMEOUT_LAST);
   end

   // Lock loss overrides every release step so rst_out is only ever re-asserted as a whole.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state   <= PLL_RESET;
         cnt     <= '0;
         pll_rst <= 1'b1;
         rst_out <= ALL_ONES;
         ready   <= 1'b0;
      end else if (ev_loss) begin
         state   <= PLL_RESET;
         cnt     <= '0;
         pll_rst <= 1'b1;
         rst_out <= ALL_ONES;
         ready   <= 1'b0;
      end else begin
         case (state)
            PLL_RESET: begin
               if (cnt == RST_LAST) begin
                  state   <= WAIT_LOCK;
                  cnt     <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (ev_timeout) begin
                  state   <= PLL_RESET;
                  cnt     <= '0;
                  pll_rst <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABLE: begin
               if (!locked_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  cnt <= '0;
                  if (NUM_DOMAINS == 1) begin
                     state   <= RUN;
                     rst_out <= '0;
                     ready   <= 1'b1;
                  end else begin
                     state   <= RELEASE;
                     rst_out <= ALL_ONES << 1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RELEASE: begin
               // Each step clears the lowest still-asserted bit, giving a strictly ascending release.
               if (cnt == STAGGER_LAST) begin
                  cnt     <= '0;
                  rst_out <= rst_out << 1;
                  if (rst_out == LAST_BIT) begin
                     state <= RUN;
                     ready <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               rst_out <= '0;
               ready   <= 1'b1;
            end
            default: begin
               state   <= PLL_RESET;
               cnt     <= '0;
               pll_rst <= 1'b1;
               rst_out <= ALL_ONES;
               ready   <= 1'b0;
            end
         endcase
      end
   end

`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // A clear coinciding with an event leaves that single event counted.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         timeout_cnt   <= '0;
         lock_lost_cnt <= '0;
      end else begin
         if (ev_timeout) begin
            if (clr_cnt)                   timeout_cnt <= CNT_W'(1);
            else if (timeout_cnt != CNT_MAX) timeout_cnt <= timeout_cnt + 1'b1;
         end else if (clr_cnt) begin
            timeout_cnt <= '0;
         end

         if (ev_loss) begin
            if (clr_cnt)                     lock_lost_cnt <= CNT_W'(1);
            else if (lock_lost_cnt != CNT_MAX) lock_lost_cnt <= lock_lost_cnt + 1'b1;
         end else if (clr_cnt) begin
            lock_lost_cnt <= '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mandebrot_plot_clk_rst_seq.sv
// tb/tb_mandebrot_plot_clk_rst_seq.sv - self-checking bench for mandebrot_plot_clk_rst_seq against a timing model
module tb_mandebrot_plot_clk_rst_seq;

   localparam int N   = 3;
   localparam int PR  = 4;
   localparam int LT  = 32;
   localparam int LS  = 8;
   localparam int ST  = 3;
   localparam int CW  = 2;
   localparam int SAT = (1 << CW) - 1;

   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_STAB = 2;
   localparam int P_REL  = 3;
   localparam int P_RUN  = 4;

   logic         refclk = 1'b0;
   logic         rst;
   logic         locked_raw;
   logic         pll_rst;
   logic [N-1:0] rst_out;
   logic         ready;
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
   logic          clr_cnt;
   logic [CW-1:0] lock_lost_cnt;
   logic [CW-1:0] timeout_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int tk       = 0;

   int m_phase, m_t, m_to, m_lost;
   bit h1, h2;

   mandebrot_plot_clk_rst_seq #(
      .NUM_DOMAINS    (N),
      .PLL_RST_CYCLES (PR),
      .LOCK_TIMEOUT   (LT),
      .LOCK_STABLE    (LS),
      .STAGGER        (ST),
      .CNT_W          (CW)
   ) u_dut (
      .refclk        (refclk),
      .rst           (rst),
      .locked_raw    (locked_raw),
      .pll_rst       (pll_rst),
      .rst_out       (rst_out),
      .ready         (ready)
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
      ,
      .clr_cnt       (clr_cnt),
      .lock_lost_cnt (lock_lost_cnt),
      .timeout_cnt   (timeout_cnt)
`endif
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_RST;
      m_t     = 0;
      m_to    = 0;
      m_lost  = 0;
      h1      = 1'b0;
      h2      = 1'b0;
   endtask

   // Released bit count grows by one every ST cycles from the first release cycle.
   function automatic logic [N-1:0] exp_rst_out();
      logic [N-1:0] v;
      int rel;
      v = '1;
      if (m_phase == P_RUN) begin
         v = '0;
      end else if (m_phase == P_REL) begin
         rel = m_t / ST + 1;
         for (int i = 0; i < N; i++)
            if (i < rel) v[i] = 1'b0;
      end
      return v;
   endfunction

   task automatic model_step(input bit raw, input bit clr);
      bit ls, ev_to, ev_loss;
      ls      = h2;
      h2      = h1;
      h1      = raw;
      ev_to   = 1'b0;
      ev_loss = 1'b0;
      if ((m_phase == P_REL || m_phase == P_RUN) && !ls) begin
         m_phase = P_RST;
         m_t     = 0;
         ev_loss = 1'b1;
      end else begin
         case (m_phase)
            P_RST: begin
               m_t++;
               if (m_t == PR) begin m_phase = P_WAIT; m_t = 0; end
            end
            P_WAIT: begin
               if (ls) begin
                  m_phase = P_STAB; m_t = 0;
               end else begin
                  m_t++;
                  if (m_t == LT) begin m_phase = P_RST; m_t = 0; ev_to = 1'b1; end
               end
            end
            P_STAB: begin
               if (!ls) begin
                  m_phase = P_WAIT; m_t = 0;
               end else begin
                  m_t++;
                  if (m_t == LS) begin
                     m_t     = 0;
                     m_phase = (N == 1) ? P_RUN : P_REL;
                  end
               end
            end
            P_REL: begin
               m_t++;
               if (m_t / ST + 1 >= N) m_phase = P_RUN;
            end
            default: ;
         endcase
      end
      if (ev_to)    m_to = clr ? 1 : ((m_to == SAT) ? SAT : m_to + 1);
      else if (clr) m_to = 0;
      if (ev_loss)  m_lost = clr ? 1 : ((m_lost == SAT) ? SAT : m_lost + 1);
      else if (clr) m_lost = 0;
   endtask

   task automatic tick(input bit raw, input bit clr);
      locked_raw = raw;
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
      clr_cnt = clr;
`endif
      @(posedge refclk);
      tk++;
      model_step(raw, clr);
      @(negedge refclk);
      chk("pll_rst", 32'(pll_rst), 32'(m_phase == P_RST));
      chk("rst_out", 32'(rst_out), 32'(exp_rst_out()));
      chk("ready", 32'(ready), 32'(m_phase == P_RUN));
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
      chk("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
      chk("lock_lost_cnt", 32'(lock_lost_cnt), 32'(m_lost));
`endif
   endtask

   initial begin
      int  rise_tick, rel_tick, last_rise, prev_rise, width;
      bit  prev_p, counting, seen100, raw;

      rst        = 1'b1;
      locked_raw = 1'b0;
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
      clr_cnt = 1'b0;
`endif
      model_reset();
      repeat (3) @(negedge refclk);
      chk("reset pll_rst", 32'(pll_rst), 32'd1);
      chk("reset rst_out", 32'(rst_out), 32'd7);
      chk("reset ready", 32'(ready), 32'd0);
      rst = 1'b0;

      // Bring-up: lock rises 10 cycles after reset release.
      repeat (10) tick(1'b0, 1'b0);
      rise_tick = tk + 1;
      rel_tick  = -1;
      for (int i = 0; i < 60 && ready !== 1'b1; i++) begin
         tick(1'b1, 1'b0);
         if (rel_tick < 0 && rst_out !== 3'b111) rel_tick = tk;
      end
      chk("bringup release latency", 32'(rel_tick - rise_tick + 1), 32'(2 + 1 + LS));
      chk("bringup ready", 32'(ready), 32'd1);

      // Asynchronous reset between edges while running.
      #2 rst = 1'b1;
      #1;
      chk("async pll_rst", 32'(pll_rst), 32'd1);
      chk("async rst_out", 32'(rst_out), 32'd7);
      chk("async ready", 32'(ready), 32'd0);
      model_reset();
      locked_raw = 1'b0;
      @(posedge refclk);
      @(negedge refclk);
      rst = 1'b0;

      // Lock never arrives: periodic PLL retries.
      prev_p    = 1'b1;
      counting  = 1'b0;
      width     = 0;
      last_rise = -1;
      prev_rise = -1;
      for (int i = 0; i < 200; i++) begin
         tick(1'b0, 1'b0);
         if (pll_rst === 1'b1 && !prev_p) begin
            prev_rise = last_rise;
            last_rise = tk;
            counting  = 1'b1;
            width     = 0;
            if (prev_rise > 0) chk("retry period", 32'(last_rise - prev_rise), 32'(PR + LT));
         end
         if (counting && pll_rst === 1'b1) width++;
         if (counting && pll_rst !== 1'b1) begin
            chk("pll_rst width", 32'(width), 32'(PR));
            counting = 1'b0;
         end
         prev_p = (pll_rst === 1'b1);
      end
      chk("timeout rst_out", 32'(rst_out), 32'd7);
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
      chk("timeout saturate", 32'(timeout_cnt), 32'(SAT));
`endif
      for (int i = 0; i < 80 && tk + 1 < last_rise + PR + LT; i++) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk("retry with clear", 32'(pll_rst), 32'd1);
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
      chk("clear with timeout", 32'(timeout_cnt), 32'd1);
`endif

      // Chatter: 5 high, 2 low, then steady high.
      repeat (6) tick(1'b0, 1'b0);
      repeat (5) tick(1'b1, 1'b0);
      repeat (2) tick(1'b0, 1'b0);
      chk("chatter no release", 32'(rst_out), 32'd7);
      rise_tick = tk + 1;
      rel_tick  = -1;
      for (int i = 0; i < 60 && ready !== 1'b1; i++) begin
         tick(1'b1, 1'b0);
         if (rel_tick < 0 && rst_out !== 3'b111) rel_tick = tk;
      end
      chk("chatter release latency", 32'(rel_tick - rise_tick + 1), 32'(2 + 1 + LS));
      chk("chatter ready", 32'(ready), 32'd1);
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
      chk("chatter no loss", 32'(lock_lost_cnt), 32'd0);
`endif

      // Lock loss in RUN: one low cycle.
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      chk("loss not yet", 32'(ready), 32'd1);
      tick(1'b1, 1'b0);
      chk("loss rst_out", 32'(rst_out), 32'd7);
      chk("loss ready", 32'(ready), 32'd0);
      chk("loss pll_rst", 32'(pll_rst), 32'd1);
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
      chk("loss count", 32'(lock_lost_cnt), 32'd1);
`endif
      for (int i = 0; i < 60 && rst_out !== 3'b110; i++) tick(1'b1, 1'b0);
      chk("resequence first step", 32'(rst_out), 32'd6);

      // Lock loss while only bit 0 is released.
      tick(1'b0, 1'b0);
      seen100 = 1'b0;
      repeat (4) begin
         tick(1'b1, 1'b0);
         if (rst_out === 3'b100) seen100 = 1'b1;
      end
      chk("no step after loss", 32'(seen100), 32'd0);
      chk("mid-release loss rst_out", 32'(rst_out), 32'd7);
`ifdef MANDEBROT_PLOT_CLK_RST_SEQ_STATUS_EN
      chk("mid-release loss count", 32'(lock_lost_cnt), 32'd2);
`endif
      for (int i = 0; i < 60 && ready !== 1'b1; i++) tick(1'b1, 1'b0);
      chk("recover ready", 32'(ready), 32'd1);

      // Random lock behaviour with occasional counter clears.
      raw = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 99) < 4) raw = ~raw;
         tick(raw, ($urandom_range(0, 99) < 5));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
